lcd_bias_sequencer: RTL

Frame scheduler for the PicoLCD segment driver. It generates the 2-bit voltage codes for a 1/4-duty, 1/3-bias multiplexed LCD, with one code per COM and per segment line; each code feeds one 3-phase PWM level generator. It steps through the four COM phases and inverts polarity every frame, so the glass sees no net DC. Pixel data enters through a valid/ready shadow buffer and takes effect only at a frame boundary.

---
 rtl/lcd_bias_sequencer_if.sv | 13 +
 rtl/lcd_bias_sequencer.sv | 89 ++++++++
 2 files changed

// File: rtl/lcd_bias_sequencer_if.sv
// lcd_bias_sequencer_if: pixel-map update handshake (valid/ready) into the shadow buffer
//   upd_data  : new pixel map, bit k*NSEG+j = pixel (COM k, SEG j), 1 = on
//   upd_valid : upd_data valid
//   upd_ready : shadow buffer can accept
interface lcd_bias_sequencer_if #(
    parameter int NSEG = 8
);
    logic [4*NSEG-1:0] upd_data;
    logic              upd_valid;
    logic              upd_ready;
    modport master (output upd_data, upd_valid, input upd_ready);
    modport slave  (input upd_data, upd_valid, output upd_ready);
endinterface

// File: rtl/lcd_bias_sequencer.sv
// lcd_bias_sequencer: 1/4-duty 1/3-bias LCD frame scheduler with frame-inverted drive codes
//   clk, rst    : clock, synchronous active-high reset
//   enable      : 1 = drive display, 0 = blank (all lines 0V)
//   upd         : pixel-map update handshake (slave side)
//   com_v       : 2-bit voltage code for COM k at [2k+1:2k]
//   seg_v       : 2-bit voltage code for SEG j at [2j+1:2j]
//   frame_start : one-cycle pulse on entry to COM0 of every frame
module lcd_bias_sequencer #(
    parameter int NSEG     = 8,
    parameter int PRESCALE = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    lcd_bias_sequencer_if.slave        upd,
    output logic [7:0]                 com_v,
    output logic [2*NSEG-1:0]          seg_v,
    output logic                       frame_start
);
    localparam int         CW    = $clog2(PRESCALE);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;
    logic [0:0]        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [1:0]        com, com_n;
    logic              inv, inv_n;
    logic [4*NSEG-1:0] active, active_n, shadow, shadow_n;
    logic              pending, pending_n;
    logic [7:0]        com_v_n;
    logic [2*NSEG-1:0] seg_v_n;
    logic [NSEG-1:0]   row;
    logic              wrap, hold, fs_n, apply, xfer;
    // Outputs are registered from next-state values so they change on the
    // same edge as the state they encode.
    always_comb begin
        state_n   = enable ? DRIVE : IDLE;
        hold      = !enable || state == IDLE;
        wrap      = state == DRIVE && cnt == CW'(PRESCALE - 1);
        fs_n      = enable && (state == IDLE || (wrap && com == 2'd3));
        cnt_n     = (hold || wrap) ? '0 : cnt + 1'b1;
        com_n     = hold ? 2'd0 : com + 2'(wrap);
        inv_n     = hold ? 1'b0 : inv ^ (wrap && com == 2'd3);
        // Shadow data lands in active at every frame boundary and whenever the
        // sequencer is (or is becoming) idle; a transfer on such an edge bypasses shadow.
        apply     = fs_n || !enable;
        xfer      = upd.upd_valid && upd.upd_ready;
        active_n  = (xfer && apply) ? upd.upd_data : (apply && pending) ? shadow : active;
        shadow_n  = (xfer && !apply) ? upd.upd_data : shadow;
        pending_n = (xfer || pending) && !apply;
        row       = com_n == 2'd0 ? active_n[0 +: NSEG] :
                    com_n == 2'd1 ? active_n[NSEG +: NSEG] :
                    com_n == 2'd2 ? active_n[2*NSEG +: NSEG] : active_n[3*NSEG +: NSEG];
        com_v_n   = '0;
        seg_v_n   = '0;
        for (int k = 0; k < 4; k++)
            com_v_n[2*k +: 2] = !enable ? 2'b00 :
                                (2'(k) == com_n) ? (inv_n ? 2'b00 : 2'b11) : (inv_n ? 2'b10 : 2'b01);
        for (int j = 0; j < NSEG; j++)
            seg_v_n[2*j +: 2] = !enable ? 2'b00 :
                                row[j] ? (inv_n ? 2'b11 : 2'b00) : (inv_n ? 2'b01 : 2'b10);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            com           <= 2'd0;
            inv           <= 1'b0;
            active        <= '0;
            shadow        <= '0;
            pending       <= 1'b0;
            upd.upd_ready <= 1'b1;
            com_v         <= '0;
            seg_v         <= '0;
            frame_start   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            com           <= com_n;
            inv           <= inv_n;
            active        <= active_n;
            shadow        <= shadow_n;
            pending       <= pending_n;
            upd.upd_ready <= !pending_n;
            com_v         <= com_v_n;
            seg_v         <= seg_v_n;
            frame_start   <= fs_n;
        end
    end
endmodule
